// File: rtl/router_src_arbiter.sv
// Round-robin packet arbiter sharing one router input between 3 sources.
// Ports: clock/resetn, src_req/src_en/src_data in, src_ready/src_grant out,
//   busy in, pkt_valid/data_out/arb_active out to/for the router.
module router_src_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int NSRC       = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NSRC-1:0]   src_req,
  input  logic [NSRC-1:0]   src_en,
  input  logic [8*NSRC-1:0] src_data,
  output logic [NSRC-1:0]   src_ready,
  output logic [NSRC-1:0]   src_grant,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              arb_active
);

  localparam int GW =
    (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [1:0]      rr_q, rr_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [NSRC-1:0] elig;
  logic            xfer;
  logic            acc;
  logic            found;
  logic [1:0]      pick;
  logic [1:0]      cand;
  logic [7:0]      byte_sel;

  assign elig = src_req & src_en;

  assign xfer = (state_q == HDR)
             || (state_q == PAYLOAD)
             || (state_q == PARITY);

  assign acc = xfer & ~busy;

  always_comb begin
    byte_sel = src_data[7:0];
    case (gidx_q)
      2'd1:    byte_sel = src_data[15:8];
      2'd2:    byte_sel = src_data[23:16];
      default: byte_sel = src_data[7:0];
    endcase
  end

  assign data_out   = xfer ? byte_sel : 8'h00;
  assign src_ready  = acc ? grant_q : '0;
  assign src_grant  = grant_q;
  assign pkt_valid  = (state_q == HDR)
                   || (state_q == PAYLOAD);
  assign arb_active = (state_q != IDLE);

  // first eligible source scanning from rr_q upward, wrapping mod NSRC
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      cand = 2'((int'(rr_q) + k) % NSRC);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          gidx_d        = pick;
          rr_d    = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (acc) begin
          cnt_d = byte_sel[7:2];
          if (byte_sel[7:2] == 6'd0) state_d = PARITY;
          else                       state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (acc) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        if (acc) begin
          grant_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GW'(GAP_CYCLES);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        // leave only once the count is spent and the router is free
        if (gap_q <= GW'(1) && !busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= 2'd0;
      rr_q    <= 2'd0;
      cnt_q   <= 6'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Directed bench for router_src_arbiter.
// Source models feed queued bytes; checks go through one task.
module tb_router_src_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  src_req = '0;
  logic [2:0]  src_en = 3'b111;
  logic [23:0] src_data = '0;
  logic [2:0]  src_ready;
  logic [2:0]  src_grant;
  logic        busy = 1'b0;
  logic        pkt_valid;
  logic [7:0]  data_out;
  logic        arb_active;

  always #5 clock = ~clock;

  router_src_arbiter #(
    .GAP_CYCLES(2),
    .NSRC(3)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .src_req(src_req),
    .src_en(src_en),
    .src_data(src_data),
    .src_ready(src_ready),
    .src_grant(src_grant),
    .busy(busy),
    .pkt_valid(pkt_valid),
    .data_out(data_out),
    .arb_active(arb_active)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int         n_pv, n_par, n_gap;
  int         low_run, min_low;
  bit         seen_hi;
  logic [2:0] prev_g;
  int         glog[$];

  function automatic logic [7:0] head(input int i);
    logic [7:0] h;
    h = 8'h00;
    if (i == 0 && q0.size() != 0) h = q0[0];
    if (i == 1 && q1.size() != 0) h = q1[0];
    if (i == 2 && q2.size() != 0) h = q2[0];
    return h;
  endfunction

  task automatic upd();
    src_req  = {q2.size() != 0, q1.size() != 0,
                q0.size() != 0};
    src_data = {head(2), head(1), head(0)};
  endtask

  task automatic clr_mon();
    n_pv = 0; n_par = 0; n_gap = 0;
    low_run = 0; min_low = 99; seen_hi = 0;
    prev_g = '0;
    glog.delete();
  endtask

  task automatic step();
    logic [2:0] rdy;
    int ix;
    ix = 0;
    @(negedge clock);
    rdy = src_ready;
    if (rdy != 0) begin
      ix = rdy[0] ? 0 : (rdy[1] ? 1 : 2);
      check("data", data_out, head(ix));
      if (pkt_valid) n_pv++;
      else n_par++;
    end
    if (arb_active && src_grant == 0) n_gap++;
    if (src_grant != 0 && prev_g == 0)
      glog.push_back(src_grant[0] ? 0 :
                     (src_grant[1] ? 1 : 2));
    prev_g = src_grant;
    if (pkt_valid) begin
      if (seen_hi && low_run > 0 && low_run < min_low)
        min_low = low_run;
      seen_hi = 1;
      low_run = 0;
    end else if (seen_hi) begin
      low_run++;
    end
    @(posedge clock);
    #1;
    if (rdy != 0) begin
      if (ix == 0) void'(q0.pop_front());
      if (ix == 1) void'(q1.pop_front());
      if (ix == 2) void'(q2.pop_front());
    end
    upd();
  endtask

  function automatic bit drained(input logic [2:0] ign);
    return (q0.size() == 0 || ign[0])
        && (q1.size() == 0 || ign[1])
        && (q2.size() == 0 || ign[2]);
  endfunction

  task automatic run(input logic [2:0] ign,
                     input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (!arb_active && drained(ign)) begin
        ok = 1;
        break;
      end
    end
    check("run_done", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    busy   = 1'b0;
    src_en = 3'b111;
    q0.delete(); q1.delete(); q2.delete();
    upd();
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    clr_mon();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // single source, len 3
    do_reset();
    check("rst_grant", src_grant, 0);
    check("rst_pv", pkt_valid, 0);
    check("rst_rdy", src_ready, 0);
    check("rst_data", data_out, 0);
    check("rst_act", arb_active, 0);
    q0 = {8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5A};
    upd();
    #1;
    check("t1_pre_grant", src_grant, 0);
    step();
    check("t1_grant", src_grant, 3'b001);
    check("t1_pv_hdr", pkt_valid, 1);
    run(3'b000, 100);
    check("t1_pv_cnt", n_pv, 4);
    check("t1_par_cnt", n_par, 1);
    check("t1_gap", n_gap, 2);
    check("t1_idle_data", data_out, 0);

    // three sources, two len-1 packets each
    do_reset();
    q0 = {8'h04, 8'hC0, 8'hE0, 8'h04, 8'hC1, 8'hE1};
    q1 = {8'h05, 8'hC2, 8'hE2, 8'h05, 8'hC3, 8'hE3};
    q2 = {8'h06, 8'hC4, 8'hE4, 8'h06, 8'hC5, 8'hE5};
    upd();
    run(3'b000, 300);
    check("t2_ngrant", glog.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t2_order", glog[i], i % 3);
    check("t2_pv_cnt", n_pv, 12);
    check("t2_par_cnt", n_par, 6);
    check("t2_min_low", min_low, 4);

    // busy stall mid-payload
    do_reset();
    q0 = {8'h10, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h7E};
    upd();
    repeat (4) step();
    busy = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("t3_busy_rdy", src_ready, 0);
      check("t3_busy_data", data_out, 8'hB3);
      @(posedge clock);
      #1;
    end
    busy = 1'b0;
    run(3'b000, 100);
    check("t3_pv_cnt", n_pv, 5);
    check("t3_par_cnt", n_par, 1);

    // zero-length packet
    do_reset();
    q1 = {8'h02, 8'h3C};
    upd();
    run(3'b000, 100);
    check("t4_pv_cnt", n_pv, 1);
    check("t4_par_cnt", n_par, 1);
    check("t4_src", glog[0], 1);

    // source 1 masked, then enabled mid-packet
    do_reset();
    src_en = 3'b101;
    q0 = {8'h00, 8'h11, 8'h00, 8'h12};
    q1 = {8'h00, 8'h21};
    q2 = {8'h00, 8'h31, 8'h00, 8'h32};
    upd();
    run(3'b010, 400);
    repeat (5) step();
    check("t5_ngrant", glog.size(), 4);
    check("t5_g0", glog[0], 0);
    check("t5_g1", glog[1], 2);
    check("t5_g2", glog[2], 0);
    check("t5_g3", glog[3], 2);
    check("t5_idle", src_grant, 0);
    q0 = {8'h08, 8'h41, 8'h42, 8'h43};
    upd();
    step();
    check("t5_grant0", src_grant, 3'b001);
    src_en = 3'b111;
    step();
    check("t5_hold", src_grant, 3'b001);
    run(3'b000, 200);
    check("t5_ngrant2", glog.size(), 6);
    check("t5_g4", glog[4], 0);
    check("t5_g5", glog[5], 1);

    // reset during payload
    do_reset();
    q0 = {8'h14, 8'hD1, 8'hD2, 8'hD3,
          8'hD4, 8'hD5, 8'h6B};
    upd();
    repeat (3) step();
    check("t6_mid_pv", pkt_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_grant", src_grant, 0);
    check("t6_pv", pkt_valid, 0);
    check("t6_rdy", src_ready, 0);
    check("t6_data", data_out, 0);
    check("t6_act", arb_active, 0);
    q0 = {8'h00, 8'h51};
    q1 = {8'h00, 8'h61};
    upd();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    clr_mon();
    run(3'b000, 200);
    check("t6_first", glog[0], 0);
    check("t6_second", glog[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_src_arbiter.md
Name: router_src_arbiter

Overview:
- Shares the router's single input port (pkt_valid / data_in / busy) between three packet sources.
- Arbitration is round-robin at packet granularity; a granted source keeps the port until its parity byte is accepted.
- The block generates the router's pkt_valid itself, from the header length field, so sources only present bytes.
- Sits directly in front of the router top-level input.

Parameters:
- GAP_CYCLES, 2: minimum idle cycles, with pkt_valid low, after a parity byte before the next grant (0 allowed).
- NSRC, 3: number of sources; fixed at 3, not meant to be overridden.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- src_req  in  3  source i has a complete packet ready to send
- src_en  in  3  per-source enable mask; a disabled source is never newly granted
- src_data  in  24  source i byte in bits [8i+7:8i]; held stable until consumed
- src_ready  out  3  one-hot; byte of source i is consumed at this clock edge
- src_grant  out  3  one-hot registered grant, held for the whole packet
- busy  in  1  router busy; no byte is consumed while high
- pkt_valid  out  1  to router; high for header and payload, low for parity
- data_out  out  8  to router data_in; granted source's byte, else 8'h00
- arb_active  out  1  high in any state other than IDLE

Behaviour:
- Packet format: header byte = {len[5:0], addr[1:0]}, then len payload bytes (len 0..63), then 1 parity byte.
- States: IDLE, HDR, PAYLOAD, PARITY, GAP.
- Reset (async, resetn=0): state IDLE, src_grant=0, rr_ptr=0, byte counter=0, gap counter=0, pkt_valid=0, src_ready=0, data_out=8'h00, arb_active=0.
- Eligibility: eligible = src_req & src_en.
- IDLE: if any source is eligible, register a grant at the next edge to the first eligible source starting at rr_ptr, in order rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
  - Set rr_ptr = granted+1 mod 3 and go to HDR.
  - Latency is 1 cycle from src_req to src_grant.
  - No eligible source: stay in IDLE.
- data_out is combinational: selects the granted source's byte in HDR, PAYLOAD and PARITY; otherwise 8'h00.
- src_ready[g] = (state in HDR/PAYLOAD/PARITY) & ~busy. All other src_ready bits are 0.
  - A byte counts as accepted when src_ready is high at the clock edge.
- HDR: pkt_valid=1.
  - On accept: cnt <= header[7:2].
  - If header[7:2]==0, go to PARITY; else go to PAYLOAD.
- PAYLOAD: pkt_valid=1.
  - Each accept decrements cnt.
  - An accept with cnt==1 goes to PARITY.
- PARITY: pkt_valid=0.
  - On accept: src_grant <= 0.
  - If GAP_CYCLES==0, go to IDLE; else load the gap counter with GAP_CYCLES and go to GAP.
- GAP: pkt_valid=0 and the grant is cleared.
  - Decrement the gap counter each cycle.
  - Go to IDLE when the counter reaches 0 AND busy==0. If busy is still high, wait in GAP.
- busy high in any transfer state: hold state, cnt and outputs; no counter changes.
- src_req and src_en are sampled only in IDLE.
  - Deasserting either while granted does not abort the packet; bytes continue to be consumed.
  - A source must keep src_req high until its parity byte is consumed.
- Simultaneous requests: round-robin order only; no priority by index beyond rr_ptr.
- Back-to-back packets from one source are allowed. The same source can win again only if the others are not eligible.
- Reset mid-packet: immediate return to IDLE with grant cleared. The partial packet is abandoned; the router's own reset is responsible for cleanup.

Test Plan:
- Reset, then single source: src_req=3'b001, header 8'h0D (len 3, addr 1), 3 payload bytes, parity.
  -> src_grant=001 one cycle after req.
  -> pkt_valid high for exactly 4 accepted bytes, low on the parity byte.
  -> GAP lasts 2 cycles, then IDLE.
- All three requesting continuously, each sending a len-1 packet.
  -> Grant order 0,1,2,0,1,2.
  -> pkt_valid drops for at least 2 cycles between packets.
- busy asserted for 5 cycles in the middle of the payload.
  -> src_ready=0 and data_out holds the same byte for those cycles; cnt unchanged.
  -> Packet completes with the correct byte count.
- Zero-length packet, header 8'h02.
  -> HDR goes straight to PARITY; pkt_valid high for 1 byte only.
- src_en=3'b101 with all requesting.
  -> Source 1 is never granted; grants alternate 0,2.
  -> Setting src_en[1]=1 mid-packet takes effect only at the next IDLE.
- resetn pulsed low during PAYLOAD.
  -> All outputs return to reset values asynchronously.
  -> Arbitration restarts with rr_ptr=0.
